prga_bitstream_shifter: RTL and testbench

PRGA_BITSTREAM_SHIFTER -- requirements
Module: prga_bitstream_shifter

---
 rtl/prga_bitstream_shifter.sv | 125 ++++++++++++
 tb/tb_prga_bitstream_shifter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prga_bitstream_shifter.sv
// prga_bitstream_shifter: serialises upstream configuration words MSB-first onto the
// PRGA scan chain, lets the chain settle, then flags the programming pass as done.
module prga_bitstream_shifter #(
   parameter int WORD_W        = 32,
   parameter int CNT_W         = 24,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic              prog_clk,
   input  logic              prog_rst,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  cfg_nbits,
   input  logic              s_valid,
   input  logic [WORD_W-1:0] s_data,
   output logic              s_ready,
   output logic              prog_we,
   output logic              prog_din,
   input  logic              prog_dout,
   input  logic              prog_we_o,
   output logic              prog_done,
   output logic              busy,
   output logic [CNT_W-1:0]  bits_left,
   output logic [CNT_W-1:0]  echo_cnt
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int SC_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SETTLE, DONE} state_t;

   state_t            state, state_next;
   logic [WORD_W-1:0] shreg, shreg_next;
   logic [IDX_W-1:0]  bit_idx, bit_idx_next;
   logic [SC_W-1:0]   settle_cnt;
   logic              last_in_word;
   logic              load_word;
   logic              start_accept;
   logic              dout_unused;

   assign dout_unused  = prog_dout;
   assign busy         = (state != IDLE) && (state != DONE);
   assign last_in_word = (bit_idx == IDX_W'(WORD_W - 1));
   assign start_accept = start && !abort && !busy;

   // A new word is only taken on the last bit of the current one, so the stream
   // continues without a bubble; a missing word falls back to LOAD and stalls the chain.
   always_comb begin
      state_next = state;
      load_word  = 1'b0;
      s_ready    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) state_next = (cfg_nbits != '0) ? LOAD : SETTLE;
         end
         LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               load_word  = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            s_ready = last_in_word && (bits_left > CNT_W'(1));
            if (bits_left == CNT_W'(1)) begin
               state_next = SETTLE;
            end else if (last_in_word) begin
               if (s_valid) load_word = 1'b1;
               else         state_next = LOAD;
            end
         end
         SETTLE: begin
            if (int'(settle_cnt) >= SETTLE_CYCLES - 1) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
      if (abort) begin
         state_next = IDLE;
         load_word  = 1'b0;
      end
   end

   always_comb begin
      shreg_next   = shreg;
      bit_idx_next = bit_idx;
      if (load_word) begin
         shreg_next   = s_data;
         bit_idx_next = '0;
      end else if (state == SHIFT) begin
         shreg_next   = shreg << 1;
         bit_idx_next = bit_idx + 1'b1;
      end
   end

   // prog_we/prog_din are registered from the next-state view so the chain sees
   // clean flop outputs with the word MSB in the first SHIFT cycle.
   always_ff @(posedge prog_clk or posedge prog_rst) begin
      if (prog_rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_idx    <= '0;
         settle_cnt <= '0;
         prog_we    <= 1'b0;
         prog_din   <= 1'b0;
         prog_done  <= 1'b0;
         bits_left  <= '0;
         echo_cnt   <= '0;
      end else begin
         state      <= state_next;
         shreg      <= shreg_next;
         bit_idx    <= bit_idx_next;
         settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
         prog_we    <= (state_next == SHIFT);
         prog_din   <= (state_next == SHIFT) && shreg_next[WORD_W-1];
         prog_done  <= (state_next == DONE);
         if (abort)                bits_left <= '0;
         else if (start_accept)    bits_left <= cfg_nbits;
         else if (state == SHIFT)  bits_left <= bits_left - 1'b1;
         if (start_accept)
            echo_cnt <= '0;
         else if (prog_we_o && (state != IDLE) && (echo_cnt != '1))
            echo_cnt <= echo_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_prga_bitstream_shifter.sv
// tb_prga_bitstream_shifter: randomized scoreboard bench; expected chain bits are queued
// at stimulus time and a monitor pops them whenever the shifter drives prog_we.
module tb_prga_bitstream_shifter;

   localparam int SETTLE = 4;

   logic        prog_clk;
   logic        prog_rst;
   logic        start;
   logic        abort;
   logic [23:0] cfg_nbits;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic        prog_we;
   logic        prog_din;
   logic        prog_dout;
   logic        prog_we_o;
   logic        prog_done;
   logic        busy;
   logic [23:0] bits_left;
   logic [23:0] echo_cnt;

   typedef struct {
      logic [31:0] data;
      int          gap;
   } word_t;

   word_t stage_q[$];
   word_t word_q[$];
   bit    exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int pass_id  = 0;
   int pass_nbits = 0;
   bit pass_active = 0;
   int start_cyc = 0;
   int exp_holes = 0;
   int first_gap = 0;

   int we_count = 0;
   int first_we = -1;
   int last_we  = -1;
   int done_cyc = -1;

   bit front_armed = 0;
   int gap_left    = 0;

   logic [63:0] chain_we;
   logic [63:0] chain_d;

   prga_bitstream_shifter #(
      .WORD_W(32),
      .CNT_W(24),
      .SETTLE_CYCLES(SETTLE)
   ) dut (
      .prog_clk(prog_clk),
      .prog_rst(prog_rst),
      .start(start),
      .abort(abort),
      .cfg_nbits(cfg_nbits),
      .s_valid(s_valid),
      .s_data(s_data),
      .s_ready(s_ready),
      .prog_we(prog_we),
      .prog_din(prog_din),
      .prog_dout(prog_dout),
      .prog_we_o(prog_we_o),
      .prog_done(prog_done),
      .busy(busy),
      .bits_left(bits_left),
      .echo_cnt(echo_cnt)
   );

   initial begin
      prog_clk = 1'b0;
      forever #5 prog_clk = ~prog_clk;
   end

   always @(posedge prog_clk) cyc <= cyc + 1;

   // The fabric chain is a 64-stage delay line from prog_we/prog_din to the outputs.
   always @(posedge prog_clk or posedge prog_rst) begin
      if (prog_rst) begin
         chain_we <= '0;
         chain_d  <= '0;
      end else begin
         chain_we <= {chain_we[62:0], prog_we};
         chain_d  <= {chain_d[62:0], prog_din};
      end
   end
   assign prog_we_o = chain_we[63];
   assign prog_dout = chain_d[63];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Upstream source: each word withholds s_valid for 'gap' cycles in which s_ready is high.
   initial begin : driver
      bit fire;
      s_valid = 1'b0;
      s_data  = '0;
      forever begin
         @(negedge prog_clk);
         fire = s_valid && s_ready;
         if (front_armed && !s_valid && s_ready && gap_left > 0) gap_left--;
         @(posedge prog_clk);
         #1;
         if (fire && word_q.size() > 0) begin
            void'(word_q.pop_front());
            front_armed = 0;
         end
         if (word_q.size() == 0) begin
            front_armed = 0;
            gap_left    = 0;
         end else if (!front_armed) begin
            front_armed = 1;
            gap_left    = word_q[0].gap;
         end
         if (front_armed && gap_left == 0) begin
            s_valid = 1'b1;
            s_data  = word_q[0].data;
         end else begin
            s_valid = 1'b0;
         end
      end
   end

   initial begin : monitor
      int seen_id = 0;
      forever begin
         @(negedge prog_clk);
         if (seen_id != pass_id) begin
            seen_id  = pass_id;
            we_count = 0;
            first_we = -1;
            last_we  = -1;
            done_cyc = -1;
         end
         if (!prog_rst) begin
            if (pass_active) checkOutput("bits_left", 64'(bits_left), 64'(pass_nbits - we_count));
            if (prog_we) begin
               if (exp_q.size() > 0) checkOutput("prog_din", 64'(prog_din), 64'(exp_q.pop_front()));
               else                  checkOutput("spurious_prog_we", 64'(prog_we), 64'(0));
               if (first_we < 0) first_we = cyc;
               last_we = cyc;
               we_count++;
            end
            if (pass_active && prog_done && done_cyc < 0) done_cyc = cyc;
         end
      end
   end

   task automatic stageWord(input logic [31:0] data, input int gap);
      word_t w;
      w.data = data;
      w.gap  = gap;
      stage_q.push_back(w);
   endtask

   task automatic stageRandom(input int nbits);
      for (int i = 0; i < (nbits + 31) / 32; i++)
         stageWord($urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
   endtask

   task automatic launchPass(input int nbits);
      logic [31:0] w;
      exp_holes = 0;
      first_gap = (stage_q.size() > 0) ? stage_q[0].gap : 0;
      for (int i = 0; i < stage_q.size(); i++) begin
         word_q.push_back(stage_q[i]);
         if (i > 0) exp_holes += stage_q[i].gap;
      end
      for (int b = 0; b < nbits; b++) begin
         w = stage_q[b / 32].data;
         exp_q.push_back(w[31 - (b % 32)]);
      end
      stage_q.delete();
      @(posedge prog_clk); #3;
      start      = 1'b1;
      cfg_nbits  = 24'(nbits);
      pass_nbits = nbits;
      start_cyc  = cyc;
      pass_id++;
      @(posedge prog_clk); #3;
      start       = 1'b0;
      pass_active = 1'b1;
   endtask

   task automatic applyStimulus(input int nbits, input int poke_at);
      int waited = 0;
      launchPass(nbits);
      while (!prog_done && waited < 2000) begin
         if (waited + 1 == poke_at) begin
            start     = 1'b1;
            cfg_nbits = 24'd5;
         end else begin
            start = 1'b0;
         end
         @(posedge prog_clk); #3;
         waited++;
      end
      start = 1'b0;
      checkOutput("done_seen", 64'(prog_done), 64'(1));
      @(negedge prog_clk); #1;
      checkOutput("bits_shifted", 64'(we_count), 64'(nbits));
      checkOutput("exp_bits_left_over", 64'(exp_q.size()), 64'(0));
      checkOutput("words_unconsumed", 64'(word_q.size()), 64'(0));
      checkOutput("busy_in_done", 64'(busy), 64'(0));
      if (nbits > 0) begin
         checkOutput("stall_cycles", 64'(last_we - first_we + 1 - we_count), 64'(exp_holes));
         checkOutput("settle_latency", 64'(done_cyc - last_we), 64'(SETTLE + 1));
         if (first_gap == 0) checkOutput("first_bit_latency", 64'(first_we - start_cyc), 64'(2));
      end else begin
         checkOutput("empty_pass_latency", 64'(done_cyc - start_cyc), 64'(SETTLE + 1));
      end
      repeat (70) @(posedge prog_clk);
      #3;
      checkOutput("echo_cnt", 64'(echo_cnt), 64'(nbits));
      checkOutput("done_held", 64'(prog_done), 64'(1));
      pass_active = 1'b0;
   endtask

   task automatic runAbort();
      int waited = 0;
      stageWord($urandom, 0);
      stageWord($urandom, 0);
      launchPass(64);
      while (bits_left != 24'd17 && waited < 200) begin
         @(posedge prog_clk); #3;
         waited++;
      end
      checkOutput("abort_reach_17", 64'(bits_left), 64'(17));
      abort     = 1'b1;
      start     = 1'b1;
      cfg_nbits = 24'd3;
      @(posedge prog_clk); #3;
      abort       = 1'b0;
      start       = 1'b0;
      pass_active = 1'b0;
      exp_q.delete();
      word_q.delete();
      @(negedge prog_clk); #1;
      checkOutput("abort_prog_we", 64'(prog_we), 64'(0));
      checkOutput("abort_busy", 64'(busy), 64'(0));
      checkOutput("abort_done", 64'(prog_done), 64'(0));
      checkOutput("abort_bits_left", 64'(bits_left), 64'(0));
      repeat (3) begin
         @(posedge prog_clk); #3;
         checkOutput("post_abort_busy", 64'(busy), 64'(0));
         checkOutput("post_abort_done", 64'(prog_done), 64'(0));
      end
      repeat (70) @(posedge prog_clk);
   endtask

   task automatic runMidReset();
      stageRandom(100);
      launchPass(100);
      repeat (30) @(posedge prog_clk);
      #3;
      prog_rst    = 1'b1;
      pass_active = 1'b0;
      exp_q.delete();
      word_q.delete();
      #1;
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_prog_we", 64'(prog_we), 64'(0));
      checkOutput("rst_bits_left", 64'(bits_left), 64'(0));
      checkOutput("rst_echo_cnt", 64'(echo_cnt), 64'(0));
      checkOutput("rst_s_ready", 64'(s_ready), 64'(0));
      repeat (2) @(posedge prog_clk);
      #3;
      prog_rst = 1'b0;
      repeat (6) begin
         @(posedge prog_clk); #3;
         checkOutput("after_rst_busy", 64'(busy), 64'(0));
         checkOutput("after_rst_prog_we", 64'(prog_we), 64'(0));
         checkOutput("after_rst_done", 64'(prog_done), 64'(0));
      end
   endtask

   initial begin : stimulus
      int nb;
      prog_rst  = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      cfg_nbits = '0;
      #2;
      checkOutput("reset_s_ready", 64'(s_ready), 64'(0));
      checkOutput("reset_prog_we", 64'(prog_we), 64'(0));
      checkOutput("reset_prog_din", 64'(prog_din), 64'(0));
      checkOutput("reset_prog_done", 64'(prog_done), 64'(0));
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_bits_left", 64'(bits_left), 64'(0));
      checkOutput("reset_echo_cnt", 64'(echo_cnt), 64'(0));
      repeat (2) @(posedge prog_clk);
      #3;
      prog_rst = 1'b0;

      $display("[TB] two full words, spurious start while busy");
      stageWord(32'hA5A5_0001, 0);
      stageWord(32'h8000_00FF, 0);
      applyStimulus(64, 10);

      $display("[TB] partial final word");
      stageWord(32'hFFFF_FFFF, 0);
      stageWord(32'hF0F0_0000, 0);
      applyStimulus(40, 0);

      $display("[TB] 10-cycle underrun between words");
      stageWord($urandom, 0);
      stageWord($urandom, 10);
      applyStimulus(64, 0);

      $display("[TB] empty pass");
      applyStimulus(0, 0);

      $display("[TB] abort at bits_left 17");
      runAbort();

      for (int p = 0; p < 6; p++) begin
         nb = int'($urandom_range(1, 130));
         $display("[TB] random pass %0d, %0d bits", p, nb);
         stageRandom(nb);
         applyStimulus(nb, 0);
      end

      $display("[TB] reset mid-pass");
      runMidReset();

      nb = int'($urandom_range(1, 96));
      stageRandom(nb);
      applyStimulus(nb, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
